// File: rtl/aes.sv
// Power-on self-test for an iterative AES datapath (128/192/256-bit keys).
//
// After reset the block walks all three key sizes. For each size it expands the
// key into the round-key store, encrypts the known-answer plaintext and checks
// the ciphertext, then decrypts the known-answer ciphertext and checks for the
// plaintext. Each check that matches sets a sticky pass flag.
//
// Ports:
//   clk     system clock, rising edge
//   rst_n   asynchronous active-low reset; clears flags and restarts the test
//   enable  display enable; combinationally gates all six pass outputs
//   e128/d128, e192/d192, e256/d256
//           encrypt/decrypt known-answer pass indicators per key size
module aes (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic e128,
  output logic d128,
  output logic e192,
  output logic d192,
  output logic e256,
  output logic d256
);

  localparam logic [127:0] PlainText = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] Ct128     = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] Ct192     = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] Ct256     = 128'h8ea2b7ca516745bfeafc49904b496089;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StExpand = 3'd1,
    StEnc    = 3'd2,
    StChkE   = 3'd3,
    StDec    = 3'd4,
    StChkD   = 3'd5,
    StDone   = 3'd6
  } state_e;

  // ---------------------------------------------------------------------------
  // GF(2^8) arithmetic and round transforms
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (maps 0 to 0, as AES requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = x;
    for (int i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
    logic [7:0] i;
    i = gf_inv(b);
    return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]} ^ {i[3:0], i[7:4]}
           ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] s);
    return gf_inv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
  endfunction

  // State byte n (column n/4, row n%4) sits at bits [127-8n -: 8].
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+4-r)%4)) -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) o[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) o[127-32*c -: 32] = inv_mix_col(s[127-32*c -: 32]);
    return o;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e       fsm_q, fsm_d;
  logic [1:0]   size_q, size_d;     // 0: AES-128, 1: AES-192, 2: AES-256
  logic [5:0]   cnt_q, cnt_d;       // word index in EXPAND, round in ENC/DEC
  logic [2:0]   kmod_q, kmod_d;     // word index mod Nk during EXPAND
  logic [7:0]   rcon_q, rcon_d;
  logic [127:0] state_q, state_d;
  logic [5:0]   flags_q, flags_d;   // {e128, d128, e192, d192, e256, d256}

  // Round-key store. Every word is written by EXPAND before any read, so it
  // needs no reset.
  logic [31:0]  rk_q [60];

  // Per-size constants
  logic [5:0]   nk, nr, exp_last;
  logic [2:0]   nk_last;
  logic [127:0] exp_ct;
  logic [5:0]   enc_mask, dec_mask;

  always_comb begin
    nk       = 6'd4;
    nr       = 6'd10;
    exp_last = 6'd43;
    nk_last  = 3'd3;
    exp_ct   = Ct128;
    enc_mask = 6'b100000;
    dec_mask = 6'b010000;
    case (size_q)
      2'd1: begin
        nk       = 6'd6;
        nr       = 6'd12;
        exp_last = 6'd51;
        nk_last  = 3'd5;
        exp_ct   = Ct192;
        enc_mask = 6'b001000;
        dec_mask = 6'b000100;
      end
      2'd2: begin
        nk       = 6'd8;
        nr       = 6'd14;
        exp_last = 6'd59;
        nk_last  = 3'd7;
        exp_ct   = Ct256;
        enc_mask = 6'b000010;
        dec_mask = 6'b000001;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // S-boxes. The forward bank is shared: during EXPAND its top four lanes
  // perform SubWord, otherwise all sixteen perform SubBytes on the state.
  // ---------------------------------------------------------------------------
  logic [127:0] sub_in, sub_out, isub_out;
  logic [31:0]  sub_word_in;

  assign sub_in = (fsm_q == StExpand) ? {sub_word_in, 96'h0} : state_q;

  for (genvar g = 0; g < 16; g++) begin : g_sbox
    assign sub_out[127-8*g -: 8]  = sbox_fwd(sub_in[127-8*g -: 8]);
    assign isub_out[127-8*g -: 8] = sbox_inv(state_q[127-8*g -: 8]);
  end

  // ---------------------------------------------------------------------------
  // Key expansion: one word per cycle
  // ---------------------------------------------------------------------------
  logic [5:0]  prev_idx, back_idx;
  logic [31:0] prev_w, back_w, w_new;
  logic [7:0]  key_b;

  always_comb begin
    prev_idx    = (cnt_q == 6'd0) ? 6'd0 : cnt_q - 6'd1;
    back_idx    = (cnt_q >= nk) ? cnt_q - nk : 6'd0;
    prev_w      = rk_q[prev_idx];
    back_w      = rk_q[back_idx];
    sub_word_in = (kmod_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
    // The three test keys are prefixes of the byte sequence 00,01,02,...
    key_b       = {3'b000, cnt_q[2:0], 2'b00};
    if (cnt_q < nk) begin
      w_new = {key_b, key_b + 8'd1, key_b + 8'd2, key_b + 8'd3};
    end else if (kmod_q == 3'd0) begin
      w_new = back_w ^ sub_out[127:96] ^ {rcon_q, 24'h0};
    end else if (size_q == 2'd2 && kmod_q == 3'd4) begin
      w_new = back_w ^ sub_out[127:96];
    end else begin
      w_new = back_w ^ prev_w;
    end
  end

  always_ff @(posedge clk) begin
    if (fsm_q == StExpand) rk_q[cnt_q] <= w_new;
  end

  // ---------------------------------------------------------------------------
  // Round datapath
  // ---------------------------------------------------------------------------
  logic [5:0]   kround, rk_base;
  logic [127:0] round_key, enc_sr, dec_ark, enc_next, dec_next;

  always_comb begin
    // Decryption walks the schedule backwards: round j uses key Nr-j.
    kround    = (fsm_q == StDec) ? nr - cnt_q : cnt_q;
    rk_base   = kround << 2;
    round_key = {rk_q[rk_base], rk_q[rk_base + 6'd1], rk_q[rk_base + 6'd2],
                 rk_q[rk_base + 6'd3]};

    enc_sr = shift_rows(sub_out);
    if (cnt_q == 6'd0)    enc_next = PlainText ^ round_key;
    else if (cnt_q == nr) enc_next = enc_sr ^ round_key;
    else                  enc_next = mix_columns(enc_sr) ^ round_key;

    dec_ark = inv_shift_rows(isub_out) ^ round_key;
    if (cnt_q == 6'd0)    dec_next = exp_ct ^ round_key;
    else if (cnt_q == nr) dec_next = dec_ark;
    else                  dec_next = inv_mix_columns(dec_ark);
  end

  // ---------------------------------------------------------------------------
  // Sequencer
  // ---------------------------------------------------------------------------
  always_comb begin
    fsm_d   = fsm_q;
    size_d  = size_q;
    cnt_d   = cnt_q;
    kmod_d  = kmod_q;
    rcon_d  = rcon_q;
    state_d = state_q;
    flags_d = flags_q;
    unique case (fsm_q)
      StIdle: begin
        fsm_d  = StExpand;
        cnt_d  = 6'd0;
        kmod_d = 3'd0;
        rcon_d = 8'h01;
      end
      StExpand: begin
        kmod_d = (kmod_q == nk_last) ? 3'd0 : kmod_q + 3'd1;
        if (cnt_q >= nk && kmod_q == 3'd0) rcon_d = xtime(rcon_q);
        if (cnt_q == exp_last) begin
          fsm_d = StEnc;
          cnt_d = 6'd0;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      StEnc: begin
        state_d = enc_next;
        if (cnt_q == nr) begin
          fsm_d = StChkE;
          cnt_d = 6'd0;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      StChkE: begin
        if (state_q == exp_ct) flags_d = flags_q | enc_mask;
        fsm_d = StDec;
        cnt_d = 6'd0;
      end
      StDec: begin
        state_d = dec_next;
        if (cnt_q == nr) begin
          fsm_d = StChkD;
          cnt_d = 6'd0;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      StChkD: begin
        if (state_q == PlainText) flags_d = flags_q | dec_mask;
        if (size_q == 2'd2) begin
          fsm_d = StDone;
        end else begin
          fsm_d  = StExpand;
          size_d = size_q + 2'd1;
          cnt_d  = 6'd0;
          kmod_d = 3'd0;
          rcon_d = 8'h01;
        end
      end
      StDone: ;
      default: fsm_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= StIdle;
      size_q  <= 2'd0;
      cnt_q   <= 6'd0;
      kmod_q  <= 3'd0;
      rcon_q  <= 8'h01;
      state_q <= 128'h0;
      flags_q <= 6'b000000;
    end else begin
      fsm_q   <= fsm_d;
      size_q  <= size_d;
      cnt_q   <= cnt_d;
      kmod_q  <= kmod_d;
      rcon_q  <= rcon_d;
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

  assign e128 = flags_q[5] & enable;
  assign d128 = flags_q[4] & enable;
  assign e192 = flags_q[3] & enable;
  assign d192 = flags_q[2] & enable;
  assign e256 = flags_q[1] & enable;
  assign d256 = flags_q[0] & enable;

endmodule

// File: tb/tb_aes.sv
// Directed bench for the AES self-test block: reset behaviour, full-run pass
// flags and their cycle of arrival, per-size ENC/DEC results, enable gating
// without a clock, mid-run reset and a run with the display disabled.
module tb_aes;

  logic clk = 1'b0;
  bit   clk_run = 1'b1;
  logic rst_n;
  logic enable;
  logic e128, d128, e192, d192, e256, d256;
  logic [5:0] leds;

  assign leds = {e128, d128, e192, d192, e256, d256};

  aes dut (
    .clk   (clk),
    .rst_n (rst_n),
    .enable(enable),
    .e128  (e128),
    .d128  (d128),
    .e192  (e192),
    .d192  (d192),
    .e256  (e256),
    .d256  (d256)
  );

  always begin
    #5;
    if (clk_run) clk = ~clk;
  end

  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;

  logic [127:0] exp_ct [3];
  int           exp_rise [6];
  string        led_name [6];
  int           n_cmp = 0;
  int           n_err = 0;
  int           rise [6];
  logic [5:0]   first_pat;
  int           n_chke, n_chkd;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Runs ncyc clock cycles counted from reset release, recording the cycle at
  // which each output first rises and the first nonzero output pattern.
  task automatic run(input int ncyc, input bit probe);
    logic [5:0] prev;
    for (int b = 0; b < 6; b++) rise[b] = -1;
    first_pat = 6'b0;
    n_chke    = 0;
    n_chkd    = 0;
    prev      = leds;
    for (int cyc = 1; cyc <= ncyc; cyc++) begin
      @(posedge clk);
      #1;
      for (int b = 0; b < 6; b++) begin
        if (leds[5-b] && !prev[5-b] && rise[b] < 0) rise[b] = cyc;
      end
      if (first_pat == 6'b0) first_pat = leds;
      prev = leds;
      if (probe) begin
        if (dut.fsm_q == 3'd3) begin
          if (n_chke < 3) check($sformatf("enc_state%0d", n_chke), dut.state_q, exp_ct[n_chke]);
          n_chke++;
        end
        if (dut.fsm_q == 3'd5) begin
          if (n_chkd < 3) check($sformatf("dec_state%0d", n_chkd), dut.state_q, PT);
          n_chkd++;
        end
      end
    end
  endtask

  initial begin
    exp_ct[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    exp_ct[1] = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    exp_ct[2] = 128'h8ea2b7ca516745bfeafc49904b496089;
    // IDLE 1 + per size (EXPAND 4(Nr+1), ENC Nr+1, CHKE 1, DEC Nr+1, CHKD 1)
    exp_rise[0] = 57;  exp_rise[1] = 69;
    exp_rise[2] = 135; exp_rise[3] = 149;
    exp_rise[4] = 225; exp_rise[5] = 241;
    led_name[0] = "e128"; led_name[1] = "d128"; led_name[2] = "e192";
    led_name[3] = "d192"; led_name[4] = "e256"; led_name[5] = "d256";

    // Reset with display enabled
    rst_n  = 1'b0;
    enable = 1'b1;
    #2;
    check("reset_leds", leds, 6'b0);
    repeat (3) @(negedge clk);
    check("reset_hold", leds, 6'b0);

    // Full run
    rst_n = 1'b1;
    run(300, 1'b1);
    for (int b = 0; b < 6; b++) check({"rise_", led_name[b]}, rise[b], exp_rise[b]);
    check("enc_probes", n_chke, 3);
    check("dec_probes", n_chkd, 3);
    check("all_pass", leds, 6'h3f);

    // Enable gating with the clock stopped
    @(negedge clk);
    clk_run = 1'b0;
    #10;
    check("en_hi0", leds, 6'h3f);
    enable = 1'b0;
    #10;
    check("en_lo", leds, 6'h00);
    enable = 1'b1;
    #10;
    check("en_hi1", leds, 6'h3f);
    clk_run = 1'b1;

    // Reset during AES-192 key expansion
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run(80, 1'b0);
    check("pre_rst_128", leds, 6'b110000);
    #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_clear", leds, 6'b0);
    @(negedge clk);
    rst_n = 1'b1;
    run(300, 1'b0);
    check("restart_first", first_pat, 6'b100000);
    check("restart_e128", rise[0], 57);
    check("restart_all", leds, 6'h3f);

    // Whole run with display disabled
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run(300, 1'b0);
    check("disabled_dark", first_pat, 6'b0);
    enable = 1'b1;
    #1;
    check("late_enable", leds, 6'h3f);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
